imm_gen_pipe: RTL and testbench

Parametrised, buffered successor to the combinational immediate generator. It sits between fetch and the register-read/execute stage.
- Accepts {instruction, PC} over a valid/ready handshake.
- Decodes the immediate format and sign-extends to XLEN.
- Precomputes the PC-relative target (pc + imm).
- Flags unrecognised opcodes.
- Queues results in a DEPTH-entry FIFO so that back-pressure never forces fetch to recompute.

---
 rtl/imm_gen_pipe_pkg.sv | 26 ++
 rtl/imm_gen_pipe_decode.sv | 61 ++++++
 rtl/imm_gen_pipe.sv | 95 +++++++++
 tb/tb_imm_gen_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the buffered immediate generator: opcodes and
// immediate-format encoding.
package imm_gen_pipe_pkg;

  localparam int unsigned TYPE_W = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [TYPE_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: format, sign-extended immediate,
// PC-relative target and illegal-opcode flag.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_target,
  output logic [TYPE_W-1:0] o_type,
  output logic              o_illegal
);

  imm_type_e   w_type;
  logic [31:0] w_imm32;

  // Every format fits in 32 bits; one sign extension to XLEN covers all.
  always_comb begin
    w_type    = IMM_NONE;
    w_imm32   = '0;
    o_illegal = 1'b0;
    case (i_inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        w_type  = IMM_I;
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          w_type  = IMM_I;
          w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_STORE: begin
        w_type  = IMM_S;
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      OP_BRANCH: begin
        w_type  = IMM_B;
        w_imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_type  = IMM_U;
        w_imm32 = {i_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        w_type  = IMM_J;
        w_imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_imm    = XLEN'($signed(w_imm32));
  assign o_target = i_pc + o_imm;
  assign o_type   = w_type;

endmodule

// File: rtl/imm_gen_pipe.sv
// Buffered immediate generator: decodes {inst, pc} on push and queues the
// results in a DEPTH-entry FIFO behind a valid/ready handshake.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_target,
  output logic [TYPE_W-1:0] out_type,
  output logic              out_illegal
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_target;
  logic [TYPE_W-1:0] w_type;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [XLEN-1:0]   r_imm     [DEPTH];
  logic [XLEN-1:0]   r_target  [DEPTH];
  logic [TYPE_W-1:0] r_type    [DEPTH];
  logic              r_illegal [DEPTH];

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .i_inst    (in_inst),
    .i_pc      (in_pc),
    .o_imm     (w_imm),
    .o_target  (w_target),
    .o_type    (w_type),
    .o_illegal (w_illegal)
  );

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm[r_wr_ptr]     <= w_imm;
      r_target[r_wr_ptr]  <= w_target;
      r_type[r_wr_ptr]    <= w_type;
      r_illegal[r_wr_ptr] <= w_illegal;
    end
  end

  // Storage is unreset; outputs are gated so an empty FIFO presents zeros.
  assign out_imm     = out_valid ? r_imm[r_rd_ptr]     : '0;
  assign out_target  = out_valid ? r_target[r_rd_ptr]  : '0;
  assign out_type    = out_valid ? r_type[r_rd_ptr]    : '0;
  assign out_illegal = out_valid ? r_illegal[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed pushes queue expected results,
// a negedge monitor pops and compares on every handshake.
module tb_imm_gen_pipe;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   nerr    = 0;
  int   nchecks = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [63:0] out_target;
  logic [2:0]  out_type;
  logic        out_illegal;

  logic        v32;
  logic        rdy32;
  logic [31:0] inst32;
  logic [31:0] pc32;
  logic        ov32;
  logic        ordy32;
  logic [31:0] imm32;
  logic [31:0] tgt32;
  logic [2:0]  typ32;
  logic        ill32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_type(out_type), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v32), .in_ready(rdy32), .in_inst(inst32), .in_pc(pc32),
    .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32),
    .out_target(tgt32), .out_type(typ32), .out_illegal(ill32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push(input logic [31:0] inst, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [63:0] tgt,
                      input logic [2:0] typ, input logic ill, output int waited);
    exp_t e;
    logic acc;
    bit   done;
    e.imm = imm; e.tgt = tgt; e.typ = typ; e.ill = ill;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    waited = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!done) begin
      nchecks++;
      nerr++;
      $display("FAIL push_timeout: inst 0x%0h never accepted", inst);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a head entry with out_ready high at negedge is consumed next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_out: imm 0x%0h target 0x%0h with no expected entry",
                 out_imm, out_target);
      end else begin
        e = sb.pop_front();
        chk("out_imm",     out_imm,            e.imm);
        chk("out_target",  out_target,         e.tgt);
        chk("out_type",    64'(out_type),      64'(e.typ));
        chk("out_illegal", 64'(out_illegal),   64'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    v32 = 1'b0; inst32 = '0; pc32 = '0; ordy32 = 1'b0;
    #2;
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_out_imm",     out_imm,          64'd0);
    chk("rst_out_target",  out_target,       64'd0);
    chk("rst_out_type",    64'(out_type),    64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Decode sweep with out_ready high; back-to-back pushes exercise push+pop.
    out_ready = 1'b1;
    push(32'h00108113, 64'h0, 64'h1, 64'h1, T_I, 1'b0, w);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    step();
    push(32'h0020A1A3, 64'h10,   64'h3, 64'h13, T_S, 1'b0, w);
    push(32'hFE0008E3, 64'h1000, 64'hFFFFFFFFFFFFFFF0, 64'h0FF0, T_B, 1'b0, w);
    push(32'h800000B7, 64'h200,  64'hFFFFFFFF80000000, 64'hFFFFFFFF80000200, T_U, 1'b0, w);
    push(32'h001000EF, 64'h100,  64'h800, 64'h900, T_J, 1'b0, w);
    push(32'h00001097, 64'h100,  64'h1000, 64'h1100, T_U, 1'b0, w);
    push(32'h0010809B, 64'h80,   64'h1, 64'h81, T_I, 1'b0, w);
    push(32'hFFFFFFFF, 64'h40,   64'h0, 64'h40, T_NONE, 1'b1, w);
    push(32'h01000013, 64'hFFFFFFFFFFFFFFF8, 64'h10, 64'h8, T_I, 1'b0, w);
    repeat (3) step();
    chk("sweep_drained", 64'(sb.size()), 64'd0);

    // Back-pressure: two accepted, third held off until a pop frees a slot.
    out_ready = 1'b0;
    push(32'h0020A1A3, 64'h10, 64'h3, 64'h13, T_S, 1'b0, w);
    push(32'h800000B7, 64'h0,  64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, T_U, 1'b0, w);
    in_valid = 1'b1; in_inst = 32'hFE0008E3; in_pc = 64'h2000;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready",  64'(in_ready),  64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("prepop_in_ready", 64'(in_ready), 64'd0);
    push(32'hFE0008E3, 64'h2000, 64'hFFFFFFFFFFFFFFF0, 64'h1FF0, T_B, 1'b0, w);
    chk("ready_after_pop_wait", 64'(w), 64'd0);
    repeat (3) step();
    chk("drain_order_done", 64'(sb.size()), 64'd0);

    // Flush with two queued plus a same-cycle input: everything dropped.
    out_ready = 1'b0;
    push(32'h00108113, 64'h0,   64'h1, 64'h1, T_I, 1'b0, w);
    push(32'h001000EF, 64'h100, 64'h800, 64'h900, T_J, 1'b0, w);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFFFFFFF; in_pc = 64'h40;
    step();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    step();
    out_ready = 1'b1;
    repeat (2) step();
    push(32'h001000EF, 64'h200, 64'h800, 64'hA00, T_J, 1'b0, w);
    repeat (2) step();

    // Asynchronous reset mid-stream drops entries without a clock edge.
    out_ready = 1'b0;
    push(32'h0020A1A3, 64'h10, 64'h3, 64'h13, T_S, 1'b0, w);
    push(32'h00108113, 64'h0,  64'h1, 64'h1, T_I, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_imm",   out_imm,        64'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready",  64'(in_ready),  64'd1);
    step();
    out_ready = 1'b1;
    push(32'h00108113, 64'h4, 64'h1, 64'h5, T_I, 1'b0, w);
    repeat (3) step();

    // XLEN=32: addiw is illegal, U and B sign-extend to 32 bits.
    ordy32 = 1'b1;
    v32 = 1'b1; inst32 = 32'h0010809B; pc32 = 32'h80;
    step();
    v32 = 1'b0;
    @(negedge clk);
    chk("x32_addiw_valid",   64'(ov32),  64'd1);
    chk("x32_addiw_illegal", 64'(ill32), 64'd1);
    chk("x32_addiw_type",    64'(typ32), 64'(T_NONE));
    chk("x32_addiw_imm",     64'(imm32), 64'd0);
    chk("x32_addiw_target",  64'(tgt32), 64'h80);
    step();
    v32 = 1'b1; inst32 = 32'h800000B7; pc32 = 32'h0;
    step();
    v32 = 1'b0;
    @(negedge clk);
    chk("x32_lui_imm",  64'(imm32), 64'h80000000);
    chk("x32_lui_type", 64'(typ32), 64'(T_U));
    step();
    v32 = 1'b1; inst32 = 32'hFE0008E3; pc32 = 32'h1000;
    step();
    v32 = 1'b0;
    @(negedge clk);
    chk("x32_beq_imm",    64'(imm32), 64'hFFFFFFF0);
    chk("x32_beq_target", 64'(tgt32), 64'h0FF0);
    step();

    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
